writeback_stage_p: RTL and testbench

- Parametrised writeback stage for the MISC-V pipeline. It contains the MEM/WB pipeline register and the result-select logic that drive the register-file write port.
- It is generalised over data width, register-address width and result sources.
- It adds a valid/ready handshake toward MEM and a wait state for late load data.
- It adds byte/word load extraction with sign or zero extension, a flush input, and a retired-instruction counter.
- It sits between the MEM stage and the register file and feeds the forwarding and hazard units.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/load_extract.sv | 34 +++
 rtl/writeback_stage_p.sv | 126 ++++++++++++
 tb/tb_writeback_stage_p.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// ============================================================================
// Module : pipe_pkg
// Brief  : Shared writeback-source codes and writeback state encoding.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  localparam logic [1:0] WB_SRC_ALU  = 2'd0;
  localparam logic [1:0] WB_SRC_MEM  = 2'd1;
  localparam logic [1:0] WB_SRC_LINK = 2'd2;
  localparam logic [1:0] WB_SRC_IMM  = 2'd3;

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_FULL      = 2'd1,
    ST_WAIT_LOAD = 2'd2
  } wb_state_t;

endpackage

`default_nettype wire

// File: rtl/load_extract.sv
// ============================================================================
// Module : load_extract
// Brief  : Byte/word load extraction with sign or zero extension.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_extract #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] word,
  input  logic              lane,
  input  logic              ld_byte,
  input  logic              ld_signed,
  output logic [DATA_W-1:0] result
);

  generate
    if (DATA_W > 8) begin : g_wide
      logic [7:0] w_byte;
      // Lane 1 is the low byte of the upper half of the word.
      assign w_byte = lane ? word[DATA_W/2 +: 8] : word[7:0];
      always_comb begin
        result = word;
        if (ld_byte) result = {{(DATA_W-8){ld_signed & w_byte[7]}}, w_byte};
      end
    end else begin : g_narrow
      assign result = word;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/writeback_stage_p.sv
// ============================================================================
// Module : writeback_stage_p
// Brief  : MEM/WB register, result select, late-load wait and retire counter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module writeback_stage_p
  import pipe_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int RADDR_W  = 3,
  parameter int CNT_W    = 16,
  parameter int ZERO_REG = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_regwrite,
  input  logic [1:0]         in_src,
  input  logic [DATA_W-1:0]  in_alu,
  input  logic [DATA_W-1:0]  in_link,
  input  logic [DATA_W-1:0]  in_imm,
  input  logic               in_ld_byte,
  input  logic               in_ld_signed,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic               mem_rvalid,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               flush,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]  rf_wdata,
  output logic               pend_valid,
  output logic [RADDR_W-1:0] pend_rd,
  output logic [CNT_W-1:0]   instret
);

  wb_state_t          r_state, w_state_nx;
  logic               r_regwrite, r_lane, r_byte, r_signed;
  logic [RADDR_W-1:0] r_rd;
  logic [DATA_W-1:0]  r_data;
  logic [CNT_W-1:0]   r_instret;

  logic               w_wait, w_accept, w_is_load;
  logic               w_lane, w_byte, w_signed;
  logic [DATA_W-1:0]  w_ext, w_sel;

  assign w_wait    = (r_state == ST_WAIT_LOAD);
  assign in_ready  = !w_wait;
  assign w_accept  = in_valid && in_ready && !flush;
  assign w_is_load = (in_src == WB_SRC_MEM);

  // While waiting, extraction uses the controls captured at accept time.
  assign w_lane   = w_wait ? r_lane   : in_alu[0];
  assign w_byte   = w_wait ? r_byte   : in_ld_byte;
  assign w_signed = w_wait ? r_signed : in_ld_signed;

  load_extract #(.DATA_W(DATA_W)) u_load_extract (
    .word      (mem_rdata),
    .lane      (w_lane),
    .ld_byte   (w_byte),
    .ld_signed (w_signed),
    .result    (w_ext)
  );

  always_comb begin
    w_sel = w_ext;
    if (!w_wait) begin
      case (in_src)
        WB_SRC_ALU:  w_sel = in_alu;
        WB_SRC_LINK: w_sel = in_link;
        WB_SRC_IMM:  w_sel = in_imm;
        default:     w_sel = w_ext;
      endcase
    end
  end

  always_comb begin
    w_state_nx = ST_EMPTY;
    case (r_state)
      ST_WAIT_LOAD: begin
        if (flush)           w_state_nx = ST_EMPTY;
        else if (mem_rvalid) w_state_nx = ST_FULL;
        else                 w_state_nx = ST_WAIT_LOAD;
      end
      default: begin
        if (w_accept) w_state_nx = (!w_is_load || mem_rvalid) ? ST_FULL : ST_WAIT_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
      r_regwrite <= 1'b0;
      r_lane     <= 1'b0;
      r_byte     <= 1'b0;
      r_signed   <= 1'b0;
      r_rd       <= '0;
      r_data     <= '0;
      r_instret  <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_accept) begin
        r_regwrite <= in_regwrite;
        r_rd       <= in_rd;
        r_lane     <= in_alu[0];
        r_byte     <= in_ld_byte;
        r_signed   <= in_ld_signed;
      end
      if (w_state_nx == ST_FULL) r_data <= w_sel;
      if (r_state == ST_FULL) r_instret <= r_instret + CNT_W'(1);
    end
  end

  assign rf_we      = (r_state == ST_FULL) && r_regwrite && !((ZERO_REG != 0) && (r_rd == '0));
  assign rf_waddr   = r_rd;
  assign rf_wdata   = r_data;
  assign pend_valid = w_wait;
  assign pend_rd    = r_rd;
  assign instret    = r_instret;

endmodule

`default_nettype wire

// File: tb/tb_writeback_stage_p.sv
// ============================================================================
// Module : tb_writeback_stage_p
// Brief  : Directed self-checking bench for writeback_stage_p.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_writeback_stage_p;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_regwrite;
  logic [1:0]  in_src;
  logic [15:0] in_alu, in_link, in_imm;
  logic        in_ld_byte, in_ld_signed;
  logic [2:0]  in_rd;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        flush;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        pend_valid;
  logic [2:0]  pend_rd;
  logic [15:0] instret;

  int checks = 0;
  int failures = 0;

  writeback_stage_p #(.DATA_W(16), .RADDR_W(3), .CNT_W(16), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_regwrite(in_regwrite), .in_src(in_src), .in_alu(in_alu), .in_link(in_link),
    .in_imm(in_imm), .in_ld_byte(in_ld_byte), .in_ld_signed(in_ld_signed), .in_rd(in_rd),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .flush(flush), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pend_valid(pend_valid), .pend_rd(pend_rd),
    .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        regwrite;
    logic [1:0]  src;
    logic [15:0] alu, link, imm;
    logic        ld_byte, ld_signed;
    logic [2:0]  rd;
    logic        rvalid;
    logic [15:0] rdata;
    logic        exp_we;
    logic [15:0] exp_wdata;
  } vec_t;

  vec_t vecs[8];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle;
    in_valid = 0; in_regwrite = 0; in_src = 0; in_alu = 0; in_link = 0; in_imm = 0;
    in_ld_byte = 0; in_ld_signed = 0; in_rd = 0; mem_rvalid = 0; mem_rdata = 0; flush = 0;
  endtask

  task automatic drive_load(input logic [2:0] rd, input logic lane, input logic sgn);
    in_valid = 1; in_regwrite = 1; in_src = 2'd1; in_alu = {15'd0, lane};
    in_ld_byte = 1; in_ld_signed = sgn; in_rd = rd; mem_rvalid = 0;
  endtask

  // Late byte load: three waiting cycles, then data arrives with other inputs scrambled.
  task automatic late_load(input string tag, input logic [2:0] rd, input logic lane,
                           input logic sgn, input logic [15:0] exp_data);
    drive_load(rd, lane, sgn);
    step;
    idle;
    in_alu = {15'd0, ~lane};
    in_ld_signed = ~sgn;
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_pend_valid"}, 32'(pend_valid), 32'd1);
      chk({tag, "_pend_rd"}, 32'(pend_rd), 32'(rd));
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_we_wait"}, 32'(rf_we), 32'd0);
      if (k < 2) step;
    end
    mem_rvalid = 1; mem_rdata = 16'h80AA;
    step;
    idle;
    chk({tag, "_we"}, 32'(rf_we), 32'd1);
    chk({tag, "_waddr"}, 32'(rf_waddr), 32'(rd));
    chk({tag, "_wdata"}, 32'(rf_wdata), 32'(exp_data));
    chk({tag, "_pend_clear"}, 32'(pend_valid), 32'd0);
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    step;
  endtask

  initial begin
    //            rw src alu       link      imm       byte sgn rd   rv rdata     we wdata
    vecs[0] = '{1'b1, 2'd0, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'd3, 1'b0, 16'h0000, 1'b1, 16'h1234};
    vecs[1] = '{1'b1, 2'd3, 16'h0000, 16'h0000, 16'h00FF, 1'b0, 1'b0, 3'd1, 1'b0, 16'h0000, 1'b1, 16'h00FF};
    vecs[2] = '{1'b1, 2'd2, 16'h0000, 16'h0042, 16'h0000, 1'b0, 1'b0, 3'd2, 1'b0, 16'h0000, 1'b1, 16'h0042};
    vecs[3] = '{1'b1, 2'd0, 16'h5555, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b0, 16'h5555};
    vecs[4] = '{1'b0, 2'd0, 16'h7777, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'd4, 1'b0, 16'h0000, 1'b0, 16'h7777};
    vecs[5] = '{1'b1, 2'd1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'd6, 1'b1, 16'hBEEF, 1'b1, 16'hBEEF};
    vecs[6] = '{1'b1, 2'd1, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 3'd7, 1'b1, 16'h1280, 1'b1, 16'hFF80};
    vecs[7] = '{1'b1, 2'd1, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b0, 3'd5, 1'b1, 16'hC312, 1'b1, 16'h00C3};

    idle;
    reset = 1;
    step;
    step;
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_wdata", 32'(rf_wdata), 32'd0);
    chk("rst_pend_valid", 32'(pend_valid), 32'd0);
    chk("rst_pend_rd", 32'(pend_rd), 32'd0);
    chk("rst_instret", 32'(instret), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    reset = 0;

    // Back-to-back accepts, one per cycle.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1; in_regwrite = vecs[i].regwrite; in_src = vecs[i].src;
      in_alu = vecs[i].alu; in_link = vecs[i].link; in_imm = vecs[i].imm;
      in_ld_byte = vecs[i].ld_byte; in_ld_signed = vecs[i].ld_signed; in_rd = vecs[i].rd;
      mem_rvalid = vecs[i].rvalid; mem_rdata = vecs[i].rdata;
      step;
      chk($sformatf("vec%0d_we", i), 32'(rf_we), 32'(vecs[i].exp_we));
      chk($sformatf("vec%0d_waddr", i), 32'(rf_waddr), 32'(vecs[i].rd));
      chk($sformatf("vec%0d_wdata", i), 32'(rf_wdata), 32'(vecs[i].exp_wdata));
      chk($sformatf("vec%0d_ready", i), 32'(in_ready), 32'd1);
      chk($sformatf("vec%0d_instret", i), 32'(instret), 32'(i));
    end
    idle;
    step;
    chk("idle_we", 32'(rf_we), 32'd0);
    chk("idle_instret", 32'(instret), 32'd8);

    late_load("lds1", 3'd5, 1'b1, 1'b1, 16'hFF80);
    chk("lds1_instret", 32'(instret), 32'd9);
    late_load("ldu0", 3'd6, 1'b0, 1'b0, 16'h00AA);
    chk("ldu0_instret", 32'(instret), 32'd10);

    // Flush a waiting load, then present its stale data.
    drive_load(3'd7, 1'b0, 1'b0);
    step;
    idle;
    flush = 1;
    chk("fl_pend_before", 32'(pend_valid), 32'd1);
    step;
    flush = 0; mem_rvalid = 1; mem_rdata = 16'h1234;
    chk("fl_pend_after", 32'(pend_valid), 32'd0);
    chk("fl_ready", 32'(in_ready), 32'd1);
    chk("fl_we", 32'(rf_we), 32'd0);
    step;
    idle;
    chk("fl_stale_we", 32'(rf_we), 32'd0);
    chk("fl_stale_pend", 32'(pend_valid), 32'd0);
    chk("fl_instret", 32'(instret), 32'd10);

    // Flush together with in_valid blocks the accept.
    in_valid = 1; in_regwrite = 1; in_src = 2'd0; in_alu = 16'hABCD; in_rd = 3'd2; flush = 1;
    step;
    idle;
    chk("flv_we", 32'(rf_we), 32'd0);
    step;
    chk("flv_instret", 32'(instret), 32'd10);

    // Reset in mid-wait dominates a simultaneous data return.
    drive_load(3'd3, 1'b1, 1'b1);
    step;
    idle;
    chk("rw_pend", 32'(pend_valid), 32'd1);
    reset = 1; mem_rvalid = 1; mem_rdata = 16'hFFFF;
    step;
    idle;
    chk("rw_we", 32'(rf_we), 32'd0);
    chk("rw_waddr", 32'(rf_waddr), 32'd0);
    chk("rw_wdata", 32'(rf_wdata), 32'd0);
    chk("rw_pend_valid", 32'(pend_valid), 32'd0);
    chk("rw_pend_rd", 32'(pend_rd), 32'd0);
    chk("rw_instret", 32'(instret), 32'd0);
    chk("rw_ready", 32'(in_ready), 32'd1);
    reset = 0;
    step;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
